// File: rtl/pulpemu_pkg.sv
// Shared types and constants for the PULPemu JTAG shift engine.
package pulpemu_pkg;

    typedef enum logic [2:0] {
        StTrst,
        StIdle,
        StLow,
        StHigh,
        StResp
    } pulpemu_jtag_state_e;

    localparam int unsigned JTAG_DIV_MIN     = 2;
    localparam int unsigned TRST_CYC_DEFAULT = 64;

endpackage

// File: rtl/pulpemu_sync.sv
// Two-flop synchroniser for a single asynchronous input, reset to 0.
module pulpemu_sync (
    input  logic ps7_clk,
    input  logic ps7_rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    always_ff @(posedge ps7_clk or negedge ps7_rst_n) begin
        if (!ps7_rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/pulpemu_jtag_shifter.sv
// JTAG shift engine: clocks out a TMS/TDI command at a programmable TCK rate and
// returns the captured TDO vector; also generates TAP reset pulses on TRST.
module pulpemu_jtag_shifter
    import pulpemu_pkg::*;
#(
    parameter  int unsigned MAX_LEN  = 32,
    parameter  int unsigned DIV_W    = 8,
    parameter  int unsigned TRST_CYC = TRST_CYC_DEFAULT,
    localparam int unsigned LEN_W    = $clog2(MAX_LEN + 1)
) (
    input  logic               ps7_clk,
    input  logic               ps7_rst_n,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic [LEN_W-1:0]   cmd_len_i,
    input  logic [MAX_LEN-1:0] cmd_tms_i,
    input  logic [MAX_LEN-1:0] cmd_tdi_i,
    input  logic [DIV_W-1:0]   clk_div_i,
    input  logic               trst_req_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic [MAX_LEN-1:0] rsp_tdo_o,
    output logic               busy_o,
    output logic               tck_o,
    output logic               tms_o,
    output logic               tdi_o,
    output logic               trst_no,
    input  logic               tdo_i
);

    localparam int unsigned TRST_W = $clog2(TRST_CYC + 1);
    localparam int unsigned CNT_W  = (DIV_W > TRST_W) ? DIV_W : TRST_W;

    pulpemu_jtag_state_e state_q;

    logic               cmd_ready_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [LEN_W-1:0]   idx_q;
    logic [LEN_W-1:0]   len_q;
    logic [DIV_W-1:0]   div_q;
    logic [MAX_LEN-1:0] tms_sh_q;
    logic [MAX_LEN-1:0] tdi_sh_q;
    logic [MAX_LEN-1:0] shadow_q;

    logic               tdo_sync;
    logic               accept;
    logic               cnt_done;
    logic               trst_done;
    logic [LEN_W-1:0]   len_eff;
    logic [DIV_W-1:0]   div_eff;
    logic [LEN_W-1:0]   idx_nxt;
    logic [MAX_LEN-1:0] shadow_upd;
    logic [MAX_LEN-1:0] tms_shift;
    logic [MAX_LEN-1:0] tdi_shift;

    pulpemu_sync u_tdo_sync (
        .ps7_clk   (ps7_clk),
        .ps7_rst_n (ps7_rst_n),
        .d_i       (tdo_i),
        .q_o       (tdo_sync)
    );

    // A pending TAP reset request masks ready so it always wins over a command.
    assign cmd_ready_o = cmd_ready_q & ~trst_req_i;

    always_comb begin
        accept     = cmd_valid_i & cmd_ready_o;
        cnt_done   = (cnt_q == CNT_W'(div_q));
        trst_done  = (cnt_q == CNT_W'(TRST_CYC - 1));
        len_eff    = (cmd_len_i > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cmd_len_i;
        div_eff    = (clk_div_i < DIV_W'(JTAG_DIV_MIN)) ? DIV_W'(JTAG_DIV_MIN) : clk_div_i;
        idx_nxt    = idx_q + LEN_W'(1);
        shadow_upd = shadow_q | (MAX_LEN'(tdo_sync) << idx_q);
        tms_shift  = tms_sh_q >> 1;
        tdi_shift  = tdi_sh_q >> 1;
    end

    always_ff @(posedge ps7_clk or negedge ps7_rst_n) begin
        if (!ps7_rst_n) begin
            state_q     <= StTrst;
            cmd_ready_q <= 1'b0;
            cnt_q       <= '0;
            idx_q       <= '0;
            len_q       <= '0;
            div_q       <= '0;
            tms_sh_q    <= '0;
            tdi_sh_q    <= '0;
            shadow_q    <= '0;
            rsp_valid_o <= 1'b0;
            rsp_tdo_o   <= '0;
            busy_o      <= 1'b1;
            tck_o       <= 1'b0;
            tms_o       <= 1'b1;
            tdi_o       <= 1'b0;
            trst_no     <= 1'b0;
        end else begin
            unique case (state_q)
                StTrst: begin
                    tck_o   <= 1'b0;
                    tms_o   <= 1'b1;
                    trst_no <= 1'b0;
                    if (trst_done) begin
                        state_q     <= StIdle;
                        trst_no     <= 1'b1;
                        cmd_ready_q <= 1'b1;
                        busy_o      <= 1'b0;
                        cnt_q       <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StIdle: begin
                    if (trst_req_i) begin
                        state_q     <= StTrst;
                        cnt_q       <= '0;
                        trst_no     <= 1'b0;
                        tms_o       <= 1'b1;
                        tck_o       <= 1'b0;
                        cmd_ready_q <= 1'b0;
                        busy_o      <= 1'b1;
                    end else if (accept) begin
                        cmd_ready_q <= 1'b0;
                        busy_o      <= 1'b1;
                        cnt_q       <= '0;
                        idx_q       <= '0;
                        shadow_q    <= '0;
                        len_q       <= len_eff;
                        div_q       <= div_eff;
                        tms_sh_q    <= cmd_tms_i;
                        tdi_sh_q    <= cmd_tdi_i;
                        if (len_eff == '0) begin
                            state_q     <= StResp;
                            rsp_valid_o <= 1'b1;
                            rsp_tdo_o   <= '0;
                        end else begin
                            state_q <= StLow;
                            tms_o   <= cmd_tms_i[0];
                            tdi_o   <= cmd_tdi_i[0];
                        end
                    end
                end
                StLow: begin
                    if (cnt_done) begin
                        state_q <= StHigh;
                        tck_o   <= 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StHigh: begin
                    if (cnt_done) begin
                        cnt_q    <= '0;
                        tck_o    <= 1'b0;
                        shadow_q <= shadow_upd;
                        idx_q    <= idx_nxt;
                        if (idx_nxt == len_q) begin
                            state_q     <= StResp;
                            rsp_valid_o <= 1'b1;
                            rsp_tdo_o   <= shadow_upd;
                        end else begin
                            // TMS/TDI change together with the TCK falling edge.
                            state_q  <= StLow;
                            tms_sh_q <= tms_shift;
                            tdi_sh_q <= tdi_shift;
                            tms_o    <= tms_shift[0];
                            tdi_o    <= tdi_shift[0];
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StResp: begin
                    tck_o <= 1'b0;
                    if (rsp_ready_i) begin
                        state_q     <= StIdle;
                        rsp_valid_o <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        busy_o      <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StTrst;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulpemu_jtag_shifter.sv
// Directed bench for pulpemu_jtag_shifter with a TDI-to-TDO shift-register TAP model.
module tb_pulpemu_jtag_shifter;

    localparam int unsigned MAX_LEN = 32;
    localparam int unsigned DIV_W   = 8;
    localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1);

    logic               ps7_clk = 1'b0;
    logic               ps7_rst_n = 1'b0;
    logic               cmd_valid_i = 1'b0;
    logic               cmd_ready_o;
    logic [LEN_W-1:0]   cmd_len_i = '0;
    logic [MAX_LEN-1:0] cmd_tms_i = '0;
    logic [MAX_LEN-1:0] cmd_tdi_i = '0;
    logic [DIV_W-1:0]   clk_div_i = '0;
    logic               trst_req_i = 1'b0;
    logic               rsp_valid_o;
    logic               rsp_ready_i = 1'b0;
    logic [MAX_LEN-1:0] rsp_tdo_o;
    logic               busy_o;
    logic               tck_o;
    logic               tms_o;
    logic               tdi_o;
    logic               trst_no;
    logic               tdo_i = 1'b0;
    logic               tdi_cap = 1'b0;

    int errors = 0;
    int checks = 0;

    pulpemu_jtag_shifter dut (
        .ps7_clk     (ps7_clk),
        .ps7_rst_n   (ps7_rst_n),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_len_i   (cmd_len_i),
        .cmd_tms_i   (cmd_tms_i),
        .cmd_tdi_i   (cmd_tdi_i),
        .clk_div_i   (clk_div_i),
        .trst_req_i  (trst_req_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_tdo_o   (rsp_tdo_o),
        .busy_o      (busy_o),
        .tck_o       (tck_o),
        .tms_o       (tms_o),
        .tdi_o       (tdi_o),
        .trst_no     (trst_no),
        .tdo_i       (tdo_i)
    );

    always #5 ps7_clk = ~ps7_clk;

    // TAP model: one-bit shift register, TDI captured on TCK rise, driven onto TDO on fall.
    always @(posedge tck_o) tdi_cap = tdi_o;
    always @(negedge tck_o) tdo_i = tdi_cap;

    task automatic step();
        @(posedge ps7_clk);
        #1;
    endtask

    task automatic start_cmd(input int len, input logic [MAX_LEN-1:0] tms,
                             input logic [MAX_LEN-1:0] tdi, input int div);
        int n = 0;
        while (!cmd_ready_o && n < 300) begin
            step();
            n++;
        end
        checks++;
        if (!cmd_ready_o) begin
            errors++;
            $display("FAIL start_cmd_ready: cmd_ready_o=%0b after %0d cycles, required 1", cmd_ready_o, n);
        end
        cmd_len_i   = LEN_W'(len);
        cmd_tms_i   = tms;
        cmd_tdi_i   = tdi;
        clk_div_i   = DIV_W'(div);
        cmd_valid_i = 1'b1;
        step();
        cmd_valid_i = 1'b0;
    endtask

    // Runs a command to its response and reports what it observed; comparisons live in the tests.
    task automatic run_cmd(input int len, input logic [MAX_LEN-1:0] tms,
                           input logic [MAX_LEN-1:0] tdi, input int div, input int d_eff,
                           input bit trst_in_high, output int lat, output int pulses,
                           output bit bad_width, output bit trst_lo, output logic [MAX_LEN-1:0] tdo);
        int   low_run = 0;
        int   hi_run  = 0;
        logic prev    = 1'b0;
        int   cyc     = 1;
        pulses    = 0;
        bad_width = 1'b0;
        trst_lo   = 1'b0;
        start_cmd(len, tms, tdi, div);
        forever begin
            trst_req_i = trst_in_high && tck_o;
            if (!trst_no) trst_lo = 1'b1;
            if (tck_o) begin
                if (!prev) begin
                    pulses++;
                    if (low_run != d_eff + 1) bad_width = 1'b1;
                end
                hi_run++;
                low_run = 0;
            end else begin
                if (prev && hi_run != d_eff + 1) bad_width = 1'b1;
                hi_run = 0;
                low_run++;
            end
            prev = tck_o;
            if (rsp_valid_o || cyc >= 1000) break;
            step();
            cyc++;
        end
        trst_req_i = 1'b0;
        lat = cyc;
        tdo = rsp_tdo_o;
    endtask

    task automatic finish_rsp();
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        int  low_cnt = 0;
        bit  tms_bad = 1'b0;
        repeat (3) step();
        checks++;
        if ({tck_o, tms_o, tdi_o, trst_no, cmd_ready_o, rsp_valid_o, busy_o} !== 7'b0100001
            || rsp_tdo_o !== '0) begin
            errors++;
            $display("FAIL reset_values: tck,tms,tdi,trst_n,rdy,rvld,busy=%b tdo=%h, required 0100001 tdo=0",
                     {tck_o, tms_o, tdi_o, trst_no, cmd_ready_o, rsp_valid_o, busy_o}, rsp_tdo_o);
        end
        ps7_rst_n = 1'b1;
        while (!trst_no && low_cnt < 200) begin
            low_cnt++;
            if (tms_o !== 1'b1 || cmd_ready_o !== 1'b0) tms_bad = 1'b1;
            step();
        end
        checks++;
        if (low_cnt != 64) begin
            errors++;
            $display("FAIL trst_len: trst_no low for %0d cycles, required 64", low_cnt);
        end
        checks++;
        if (tms_bad) begin
            errors++;
            $display("FAIL trst_tms: tms_o/cmd_ready_o wrong during TRST, required tms=1 ready=0");
        end
        checks++;
        if (cmd_ready_o !== 1'b1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL trst_exit: cmd_ready_o=%b busy_o=%b, required 1 0", cmd_ready_o, busy_o);
        end
    endtask

    task automatic test_basic();
        int lat, pulses;
        bit bad, tlo;
        logic [MAX_LEN-1:0] tdo;
        run_cmd(5, 32'h1F, 32'h0, 2, 2, 1'b0, lat, pulses, bad, tlo, tdo);
        checks++;
        if (lat != 31 || pulses != 5 || bad) begin
            errors++;
            $display("FAIL basic_timing: lat=%0d pulses=%0d badwidth=%0b, required 31 5 0", lat, pulses, bad);
        end
        checks++;
        if (tdo !== 32'h0 || tms_o !== 1'b1 || tck_o !== 1'b0) begin
            errors++;
            $display("FAIL basic_rsp: tdo=%h tms=%b tck=%b, required 0 1 0", tdo, tms_o, tck_o);
        end
        finish_rsp();
        checks++;
        if (busy_o !== 1'b0 || cmd_ready_o !== 1'b1 || rsp_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle: busy=%b ready=%b rvld=%b, required 0 1 0", busy_o, cmd_ready_o, rsp_valid_o);
        end
    endtask

    task automatic test_shift();
        int lat, pulses;
        bit bad, tlo;
        logic [MAX_LEN-1:0] tdo;
        run_cmd(8, 32'h0, 32'hA5, 3, 3, 1'b0, lat, pulses, bad, tlo, tdo);
        checks++;
        if (lat != 65 || pulses != 8 || bad) begin
            errors++;
            $display("FAIL shift_timing: lat=%0d pulses=%0d badwidth=%0b, required 65 8 0", lat, pulses, bad);
        end
        checks++;
        if (tdo !== 32'h0000_004A || tdi_o !== 1'b1 || tms_o !== 1'b0) begin
            errors++;
            $display("FAIL shift_tdo: tdo=%h tdi=%b tms=%b, required 0000004a 1 0", tdo, tdi_o, tms_o);
        end
        finish_rsp();
    endtask

    task automatic test_clamp();
        int lat, pulses;
        bit bad, tlo;
        logic [MAX_LEN-1:0] tdo;
        // TDO model still holds 1 from the previous command's last TDI bit.
        run_cmd(MAX_LEN + 5, 32'h8000_0001, 32'h1234_5678, 0, 2, 1'b0, lat, pulses, bad, tlo, tdo);
        checks++;
        if (lat != 193 || pulses != 32 || bad) begin
            errors++;
            $display("FAIL clamp_timing: lat=%0d pulses=%0d badwidth=%0b, required 193 32 0", lat, pulses, bad);
        end
        checks++;
        if (tdo !== 32'h2468_ACF1 || tms_o !== 1'b1 || tdi_o !== 1'b0) begin
            errors++;
            $display("FAIL clamp_tdo: tdo=%h tms=%b tdi=%b, required 2468acf1 1 0", tdo, tms_o, tdi_o);
        end
        finish_rsp();
    endtask

    task automatic test_zero_len();
        int lat, pulses;
        bit bad, tlo;
        bit held_bad = 1'b0;
        logic [MAX_LEN-1:0] tdo;
        run_cmd(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 5, 1'b0, lat, pulses, bad, tlo, tdo);
        checks++;
        if (lat != 1 || pulses != 0 || tdo !== '0) begin
            errors++;
            $display("FAIL zero_len: lat=%0d pulses=%0d tdo=%h, required 1 0 0", lat, pulses, tdo);
        end
        for (int i = 0; i < 10; i++) begin
            step();
            if (rsp_valid_o !== 1'b1 || rsp_tdo_o !== '0 || cmd_ready_o !== 1'b0 || tck_o !== 1'b0)
                held_bad = 1'b1;
        end
        checks++;
        if (held_bad) begin
            errors++;
            $display("FAIL zero_len_hold: response not held stable, now rvld=%b tdo=%h ready=%b, required 1 0 0",
                     rsp_valid_o, rsp_tdo_o, cmd_ready_o);
        end
        finish_rsp();
        checks++;
        if (cmd_ready_o !== 1'b1 || rsp_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL zero_len_idle: ready=%b rvld=%b, required 1 0", cmd_ready_o, rsp_valid_o);
        end
    endtask

    task automatic test_trst_ignored();
        int lat, pulses;
        bit bad, tlo;
        logic [MAX_LEN-1:0] tdo;
        run_cmd(4, 32'h3, 32'hB, 2, 2, 1'b1, lat, pulses, bad, tlo, tdo);
        checks++;
        if (lat != 25 || pulses != 4 || bad || tlo) begin
            errors++;
            $display("FAIL trst_ignored: lat=%0d pulses=%0d badwidth=%0b trst_low=%0b, required 25 4 0 0",
                     lat, pulses, bad, tlo);
        end
        checks++;
        if (tdo !== 32'h6) begin
            errors++;
            $display("FAIL trst_ignored_tdo: tdo=%h, required 00000006", tdo);
        end
        finish_rsp();
    endtask

    task automatic test_trst_priority();
        int lat, pulses, low_cnt;
        bit bad, tlo;
        logic [MAX_LEN-1:0] tdo;
        trst_req_i  = 1'b1;
        cmd_valid_i = 1'b1;
        cmd_len_i   = LEN_W'(3);
        #1;
        checks++;
        if (cmd_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL trst_prio_ready: cmd_ready_o=%b with trst_req, required 0", cmd_ready_o);
        end
        step();
        trst_req_i  = 1'b0;
        cmd_valid_i = 1'b0;
        low_cnt = 0;
        while (!trst_no && low_cnt < 200) begin
            low_cnt++;
            step();
        end
        checks++;
        if (low_cnt != 64) begin
            errors++;
            $display("FAIL trst_prio_len: trst_no low for %0d cycles, required 64", low_cnt);
        end
        // TDO model holds 1 from the previous command's last TDI bit.
        run_cmd(2, 32'h0, 32'h0, 2, 2, 1'b0, lat, pulses, bad, tlo, tdo);
        checks++;
        if (lat != 13 || pulses != 2 || tdo !== 32'h1) begin
            errors++;
            $display("FAIL trst_prio_cmd: lat=%0d pulses=%0d tdo=%h, required 13 2 00000001", lat, pulses, tdo);
        end
        finish_rsp();
    endtask

    task automatic test_reset_mid();
        int n = 0;
        start_cmd(10, 32'h0, 32'h3FF, 2);
        while (!tck_o && n < 50) begin
            step();
            n++;
        end
        checks++;
        if (tck_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_tck: tck_o=%b before reset, required 1", tck_o);
        end
        #2;
        ps7_rst_n = 1'b0;
        #1;
        checks++;
        if ({tck_o, tms_o, trst_no, busy_o, rsp_valid_o, cmd_ready_o} !== 6'b010100) begin
            errors++;
            $display("FAIL reset_mid: tck,tms,trst_n,busy,rvld,rdy=%b, required 010100",
                     {tck_o, tms_o, trst_no, busy_o, rsp_valid_o, cmd_ready_o});
        end
        step();
        ps7_rst_n = 1'b1;
        n = 0;
        while (!cmd_ready_o && n < 200) begin
            step();
            n++;
        end
        checks++;
        if (cmd_ready_o !== 1'b1 || rsp_valid_o !== 1'b0 || rsp_tdo_o !== '0) begin
            errors++;
            $display("FAIL reset_mid_recover: ready=%b rvld=%b tdo=%h, required 1 0 0",
                     cmd_ready_o, rsp_valid_o, rsp_tdo_o);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_shift();
        test_clamp();
        test_zero_len();
        test_trst_ignored();
        test_trst_priority();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
